hazard_ctrl_unit: RTL and testbench

- Pipeline hazard controller for the 5-stage RISC-V core.
- Produces StallF, which gates the PC register, plus the stall and flush controls for the IF/ID, ID/EX and EX/MEM registers and the EX-stage forwarding selects.
- Adds sequential control for multi-cycle MUL/DIV ops in EX. That control is a small FSM with a latency counter that freezes the front of the pipe and injects bubbles into MEM.

---
 rtl/hazard_ctrl_unit.sv | 178 +++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RISC-V core: forwarding, load-use, branch flush, MUL/DIV stall FSM.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int MULDIV_LAT = 4,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  MemReadE,
    input  logic                  PCSrcE,
    input  logic                  MulDivE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  MulDivBusy,
    output logic [PERF_W-1:0]     StallCount,
    output logic [PERF_W-1:0]     FlushCount
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // First BUSY cycle loads LAT-2 so that EX is held for LAT-1 stall cycles in total.
    localparam logic [3:0] CNT_INIT = (MULDIV_LAT > 1) ? 4'(MULDIV_LAT - 2) : 4'd0;
    localparam bit         MULDIV_MULTI = (MULDIV_LAT > 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    md_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       muldiv_stall;
    logic       load_use;
    logic       rs1d_hit, rs2d_hit;

    // ------------------------------------------------------------------
    // MUL/DIV sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        muldiv_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (MulDivE && MULDIV_MULTI) begin
                    muldiv_stall = 1'b1;
                    state_d      = BUSY;
                    cnt_d        = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    muldiv_stall = 1'b1;
                    cnt_d        = cnt_q - 4'd1;
                end else begin
                    // Op leaves EX at this edge; a following op is picked up from IDLE.
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (rst) begin
            state_d      = IDLE;
            cnt_d        = 4'd0;
            muldiv_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    // ------------------------------------------------------------------
    // Hazard detection and control outputs
    // ------------------------------------------------------------------
    assign rs1d_hit = (RdE == Rs1D);
    assign rs2d_hit = (RdE == Rs2D);
    assign load_use = MemReadE && (RdE != '0) && (rs1d_hit || rs2d_hit);

    always_comb begin
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushM     = 1'b0;
        ForwardAE  = FWD_RF;
        ForwardBE  = FWD_RF;
        MulDivBusy = 1'b0;

        if (rst) begin
            // Keep the PC unstalled so its own reset can take effect.
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else begin
            if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
                ForwardAE = FWD_MEM;
            else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
                ForwardAE = FWD_WB;

            if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
                ForwardBE = FWD_MEM;
            else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
                ForwardBE = FWD_WB;

            MulDivBusy = (state_q == BUSY);

            if (muldiv_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else begin
                StallF = load_use;
                StallD = load_use;
                FlushD = PCSrcE;
                FlushE = load_use || PCSrcE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (rst) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (StallF)
                stall_cnt_d = stall_cnt_q + PERF_W'(1);
            if (FlushD || FlushE)
                flush_cnt_d = flush_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: vector table for combinational hazards plus MUL/DIV, reset and counter sequences.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, MemReadE, PCSrcE, MulDivE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDivBusy;
    logic [1:0] ForwardAE, ForwardBE;
    logic [31:0] StallCount, FlushCount;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_ADDR_W(5), .MULDIV_LAT(4), .PERF_W(32)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MulDivE(MulDivE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MulDivBusy(MulDivBusy),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    typedef struct {
        logic       rst, md, pc, mr, rwm, rww;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [2:0] stall;   // {StallF, StallD, StallE}
        logic [2:0] flush;   // {FlushD, FlushE, FlushM}
        logic [1:0] fa, fb;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic r, md, pc, mr, rwm, rww,
                                input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                                input logic [2:0] st, fl, input logic [1:0] fa, fb);
        vec_t v;
        v.rst = r; v.md = md; v.pc = pc; v.mr = mr; v.rwm = rwm; v.rww = rww;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
        v.rde = rde; v.rdm = rdm; v.rdw = rdw;
        v.stall = st; v.flush = fl; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_idle();
        rst = 1'b0; MulDivE = 1'b0; PCSrcE = 1'b0; MemReadE = 1'b0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stalls;
        set_idle();
        rst = 1'b1;
        next_cycle();
        next_cycle();

        //                 rst md pc mr rwm rww rs1d rs2d rs1e rs2e rde rdm rdw  stall   flush   fa     fb
        vecs[0]  = mk(1, 1, 1, 0, 1, 0, 0, 0, 5,  0,  0, 5,  0,  3'b000, 3'b111, 2'b00, 2'b00);
        vecs[1]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 5,  0,  0, 5,  5,  3'b000, 3'b000, 2'b10, 2'b00);
        vecs[2]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 5,  0,  0, 0,  5,  3'b000, 3'b000, 2'b01, 2'b00);
        vecs[3]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 3,  0,  0, 0,  0,  3'b000, 3'b000, 2'b00, 2'b00);
        vecs[4]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0,  9,  0, 9,  9,  3'b000, 3'b000, 2'b00, 2'b01);
        vecs[5]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0,  9,  0, 9,  9,  3'b000, 3'b000, 2'b00, 2'b10);
        vecs[6]  = mk(0, 0, 0, 1, 0, 0, 0, 7, 0,  0,  7, 0,  0,  3'b110, 3'b010, 2'b00, 2'b00);
        vecs[7]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0,  0,  0, 0,  0,  3'b000, 3'b000, 2'b00, 2'b00);
        vecs[8]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0,  0,  0, 0,  0,  3'b000, 3'b110, 2'b00, 2'b00);
        vecs[9]  = mk(0, 0, 1, 1, 0, 0, 7, 0, 0,  0,  7, 0,  0,  3'b110, 3'b110, 2'b00, 2'b00);
        vecs[10] = mk(0, 0, 0, 1, 0, 0, 6, 8, 0,  0,  7, 0,  0,  3'b000, 3'b000, 2'b00, 2'b00);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 7, 0, 0,  0,  7, 0,  0,  3'b000, 3'b000, 2'b00, 2'b00);
        vecs[12] = mk(0, 0, 0, 0, 1, 1, 0, 0, 31, 31, 0, 30, 31, 3'b000, 3'b000, 2'b01, 2'b01);

        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst; MulDivE = vecs[i].md; PCSrcE = vecs[i].pc; MemReadE = vecs[i].mr;
            RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
            RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
            @(negedge clk);
            chk($sformatf("v%0d StallF", i), 32'(StallF), 32'(vecs[i].stall[2]));
            chk($sformatf("v%0d StallD", i), 32'(StallD), 32'(vecs[i].stall[1]));
            chk($sformatf("v%0d StallE", i), 32'(StallE), 32'(vecs[i].stall[0]));
            chk($sformatf("v%0d FlushD", i), 32'(FlushD), 32'(vecs[i].flush[2]));
            chk($sformatf("v%0d FlushE", i), 32'(FlushE), 32'(vecs[i].flush[1]));
            chk($sformatf("v%0d FlushM", i), 32'(FlushM), 32'(vecs[i].flush[0]));
            chk($sformatf("v%0d ForwardAE", i), 32'(ForwardAE), 32'(vecs[i].fa));
            chk($sformatf("v%0d ForwardBE", i), 32'(ForwardBE), 32'(vecs[i].fb));
            chk($sformatf("v%0d MulDivBusy", i), 32'(MulDivBusy), 32'd0);
            next_cycle();
        end

        // Two back-to-back MUL/DIV ops, LAT=4: stall 3 cycles, release on the 4th, repeat.
        set_idle();
        next_cycle();
        MulDivE = 1'b1;
        stalls = 0;
        for (int c = 0; c < 8; c++) begin
            logic exp_st;
            exp_st = ((c % 4) != 3);
            @(negedge clk);
            chk($sformatf("md c%0d StallF", c), 32'(StallF), 32'(exp_st));
            chk($sformatf("md c%0d StallD", c), 32'(StallD), 32'(exp_st));
            chk($sformatf("md c%0d StallE", c), 32'(StallE), 32'(exp_st));
            chk($sformatf("md c%0d FlushM", c), 32'(FlushM), 32'(exp_st));
            if ((c % 4) != 3)
                chk($sformatf("md c%0d MulDivBusy", c), 32'(MulDivBusy), 32'((c % 4) != 0));
            if (StallF) stalls++;
            next_cycle();
        end
        chk("md total stall cycles", 32'(stalls), 32'd6);
        MulDivE = 1'b0;
        @(negedge clk);
        chk("md idle after ops StallF", 32'(StallF), 32'd0);
        next_cycle();

        // MUL/DIV start coinciding with a taken branch: branch flush suppressed.
        MulDivE = 1'b1; PCSrcE = 1'b1;
        @(negedge clk);
        chk("md+br StallF", 32'(StallF), 32'd1);
        chk("md+br FlushD", 32'(FlushD), 32'd0);
        chk("md+br FlushE", 32'(FlushE), 32'd0);
        next_cycle();
        MulDivE = 1'b0; PCSrcE = 1'b0;
        MemReadE = 1'b1; RdE = 5'd4; Rs1D = 5'd4;
        @(negedge clk);
        chk("md+lu busy FlushE", 32'(FlushE), 32'd0);
        chk("md+lu busy StallE", 32'(StallE), 32'd1);
        next_cycle();
        set_idle();
        next_cycle();
        next_cycle();

        // Reset on cycle 2 of a MUL/DIV op.
        MulDivE = 1'b1;
        @(negedge clk);
        chk("rstmid c1 StallF", 32'(StallF), 32'd1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid in rst StallF", 32'(StallF), 32'd0);
        chk("rstmid in rst FlushM", 32'(FlushM), 32'd1);
        next_cycle();
        rst = 1'b0; MulDivE = 1'b0;
        stalls = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (StallF) stalls++;
            if (c == 0) chk("rstmid busy after rst", 32'(MulDivBusy), 32'd0);
            next_cycle();
        end
        chk("rstmid residual stalls", 32'(stalls), 32'd0);

        // Performance counters: one load-use cycle then one taken-branch cycle.
        rst = 1'b1;
        next_cycle();
        set_idle();
        MemReadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        next_cycle();
        set_idle();
        PCSrcE = 1'b1;
        next_cycle();
        set_idle();
        @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf StallCount", StallCount, 32'd1);
        chk("perf FlushCount", FlushCount, 32'd2);
`else
        chk("perf StallCount", StallCount, 32'd0);
        chk("perf FlushCount", FlushCount, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
